cdc_4phase_dst_fifo: RTL and testbench

Destination-side endpoint of a four-phase (return-to-zero) req/ack clock-domain crossing, generalised in data width and output buffering. It synchronises the incoming request and captures the source-stable data into a DEPTH-entry FIFO. It acknowledges as soon as a FIFO slot is committed, without waiting for downstream consumption, and exposes a valid/ready stream in the destination clock domain. It sits in the destination domain of every CDC link that must absorb bursts while the sink is stalled.

---
 rtl/cdc_4phase_pkg.sv | 16 +
 rtl/cdc_4phase_dst_fifo_sync.sv | 24 ++
 rtl/cdc_4phase_dst_fifo.sv | 135 +++++++++++++
 tb/tb_cdc_4phase_dst_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_4phase_pkg.sv
// Shared types for the four-phase req/ack CDC endpoints.
// Destination FSM encoding and a width helper for FIFO occupancy.
package cdc_4phase_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_SPACE = 2'd1,
        ACK        = 2'd2
    } dst_state_e;

    // Bits needed to hold an occupancy count of 0..depth.
    function automatic int fill_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cdc_4phase_dst_fifo_sync.sv
// Multi-flop synchroniser for a single-bit level crossing into clk_i.
// Output is the last stage; STAGES must be at least 2.
module cdc_4phase_dst_fifo_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_4phase_dst_fifo.sv
// Destination endpoint of a four-phase req/ack crossing: captures source data
// into a small FIFO, acks once a slot is committed, and streams valid/ready.
module cdc_4phase_dst_fifo
    import cdc_4phase_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          async_req_i,
    input  logic [DATA_WIDTH-1:0]         async_data_i,
    (* dont_touch = "true" *)
    output logic                          async_ack_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [fill_width(DEPTH)-1:0]  fill_o,
    output logic [CNT_WIDTH-1:0]          xfer_cnt_o,
    output logic                          proto_err_o
);

    localparam int FW = fill_width(DEPTH);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    (* dont_touch = "true" *) logic req_s;
    (* dont_touch = "true" *) logic ack_q;

    dst_state_e              state_q, state_n;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [PW-1:0]           wptr_q, rptr_q;
    logic [FW-1:0]           fill_q;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    err_q;
    logic                    push, pop, full, set_err;

    cdc_4phase_dst_fifo_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (async_req_i),
        .q_o    (req_s)
    );

    // Full uses the registered occupancy, so a same-cycle pop never frees a slot.
    assign full    = (fill_q == FW'(DEPTH));
    assign valid_o = (fill_q != '0);
    assign pop     = valid_o && ready_i;

    always_comb begin
        state_n = state_q;
        push    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (!full) begin
                        push    = 1'b1;
                        state_n = ACK;
                    end else begin
                        state_n = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                if (!req_s) begin
                    set_err = 1'b1;
                    state_n = IDLE;
                end else if (!full) begin
                    push    = 1'b1;
                    state_n = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            ack_q   <= (state_n == ACK);
            if (push) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (set_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage is cleared on reset so data_o reads zero until the first push.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= async_data_i;
                wptr_q        <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    assign async_ack_o = ack_q;
    assign data_o      = mem_q[rptr_q];
    assign fill_o      = fill_q;
    assign xfer_cnt_o  = cnt_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_cdc_4phase_dst_fifo.sv
// Directed bench for cdc_4phase_dst_fifo: a DEPTH=2 instance for handshake,
// stall, error, push/pop and reset cases, and a DEPTH=3/CNT_WIDTH=4 instance for wrap.
module tb_cdc_4phase_dst_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_a   [2];
    logic [31:0] data_a  [2];
    logic        ready_a [2];
    logic        ack_a   [2];
    logic [31:0] dout_a  [2];
    logic        valid_a [2];
    logic [1:0]  fill_a  [2];
    logic        err_a   [2];
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cdc_4phase_dst_fifo #(
        .DATA_WIDTH(32), .SYNC_STAGES(2), .DEPTH(2), .CNT_WIDTH(16)
    ) u_dut0 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .async_req_i  (req_a[0]),
        .async_data_i (data_a[0]),
        .async_ack_o  (ack_a[0]),
        .data_o       (dout_a[0]),
        .valid_o      (valid_a[0]),
        .ready_i      (ready_a[0]),
        .fill_o       (fill_a[0]),
        .xfer_cnt_o   (cnt0),
        .proto_err_o  (err_a[0])
    );

    cdc_4phase_dst_fifo #(
        .DATA_WIDTH(32), .SYNC_STAGES(2), .DEPTH(3), .CNT_WIDTH(4)
    ) u_dut1 (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .async_req_i  (req_a[1]),
        .async_data_i (data_a[1]),
        .async_ack_o  (ack_a[1]),
        .data_o       (dout_a[1]),
        .valid_o      (valid_a[1]),
        .ready_i      (ready_a[1]),
        .fill_o       (fill_a[1]),
        .xfer_cnt_o   (cnt1),
        .proto_err_o  (err_a[1])
    );

    typedef struct {
        logic [31:0] data;
        int          pops;
        logic [1:0]  exp_fill;
        logic [31:0] exp_head;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Waits on negedges for ack to reach val; an expired budget is a failed check.
    task automatic wait_ack(input int d, input logic val, input int max, output int lat);
        lat = 0;
        while (ack_a[d] !== val && lat < max) begin
            @(negedge clk);
            lat++;
        end
        check("ack_wait", 32'(ack_a[d]), 32'(val));
    endtask

    task automatic send(input int d, input logic [31:0] data);
        int lat;
        data_a[d] = data;
        req_a[d]  = 1'b1;
        wait_ack(d, 1'b1, 20, lat);
        if (d == 0) exp0_q.push_back(data);
        else        exp1_q.push_back(data);
        req_a[d] = 1'b0;
        wait_ack(d, 1'b0, 20, lat);
    endtask

    task automatic pop_one(input int d);
        logic [31:0] e;
        if (d == 0) e = (exp0_q.size() > 0) ? exp0_q.pop_front() : 32'hDEAD_BEEF;
        else        e = (exp1_q.size() > 0) ? exp1_q.pop_front() : 32'hDEAD_BEEF;
        check("pop_valid", 32'(valid_a[d]), 32'd1);
        check("pop_data", dout_a[d], e);
        ready_a[d] = 1'b1;
        @(negedge clk);
        ready_a[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;

        vecs[0] = '{32'h100, 0, 2'd1, 32'h100, 4'd1};
        vecs[1] = '{32'h101, 0, 2'd2, 32'h100, 4'd2};
        vecs[2] = '{32'h102, 1, 2'd2, 32'h101, 4'd3};
        vecs[3] = '{32'h103, 2, 2'd1, 32'h103, 4'd4};
        vecs[4] = '{32'h104, 0, 2'd2, 32'h103, 4'd5};
        vecs[5] = '{32'h105, 1, 2'd2, 32'h104, 4'd6};
        vecs[6] = '{32'h106, 2, 2'd1, 32'h106, 4'd7};
        vecs[7] = '{32'h107, 0, 2'd2, 32'h106, 4'd8};
        vecs[8] = '{32'h108, 1, 2'd2, 32'h107, 4'd9};
        vecs[9] = '{32'h109, 0, 2'd3, 32'h107, 4'd10};

        for (int d = 0; d < 2; d++) begin
            req_a[d]   = 1'b0;
            data_a[d]  = '0;
            ready_a[d] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack_a[0]), 32'd0);
        check("rst_valid", 32'(valid_a[0]), 32'd0);
        check("rst_data", dout_a[0], 32'd0);
        check("rst_fill", 32'(fill_a[0]), 32'd0);
        check("rst_cnt", 32'(cnt0), 32'd0);
        check("rst_err", 32'(err_a[0]), 32'd0);
        check("rst_cnt1", 32'(cnt1), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single transfer with ready held high
        ready_a[0] = 1'b1;
        data_a[0]  = 32'hA5A5_0001;
        req_a[0]   = 1'b1;
        n = 0;
        while (!valid_a[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("valid_lat", 32'(n), 32'd3);
        check("single_data", dout_a[0], 32'hA5A5_0001);
        check("single_ack", 32'(ack_a[0]), 32'd1);
        req_a[0] = 1'b0;
        wait_ack(0, 1'b0, 20, lat);
        check("ack_fall_lat", 32'(lat), 32'd3);
        check("single_cnt", 32'(cnt0), 32'd1);
        check("single_fill", 32'(fill_a[0]), 32'd0);
        ready_a[0] = 1'b0;

        // Burst while stalled: third transfer parks in WAIT_SPACE
        send(0, 32'hB000_0001);
        send(0, 32'hB000_0002);
        check("burst_fill2", 32'(fill_a[0]), 32'd2);
        data_a[0] = 32'hB000_0003;
        req_a[0]  = 1'b1;
        repeat (6) @(negedge clk);
        check("burst_wait_ack", 32'(ack_a[0]), 32'd0);
        check("burst_wait_fill", 32'(fill_a[0]), 32'd2);
        pop_one(0);
        check("burst_pop_fill", 32'(fill_a[0]), 32'd1);
        check("burst_no_fallthru", 32'(ack_a[0]), 32'd0);
        @(negedge clk);
        check("burst_push_fill", 32'(fill_a[0]), 32'd2);
        check("burst_push_ack", 32'(ack_a[0]), 32'd1);
        exp0_q.push_back(32'hB000_0003);
        req_a[0] = 1'b0;
        wait_ack(0, 1'b0, 20, lat);
        pop_one(0);
        pop_one(0);
        check("burst_drain_fill", 32'(fill_a[0]), 32'd0);

        // Protocol violation: req withdrawn while waiting for space
        send(0, 32'hD000_0001);
        send(0, 32'hD000_0002);
        data_a[0] = 32'hD000_0003;
        req_a[0]  = 1'b1;
        repeat (5) @(negedge clk);
        req_a[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("err_set", 32'(err_a[0]), 32'd1);
        check("err_fill", 32'(fill_a[0]), 32'd2);
        check("err_ack", 32'(ack_a[0]), 32'd0);
        check("err_cnt", 32'(cnt0), 32'd6);
        pop_one(0);
        pop_one(0);
        repeat (5) @(negedge clk);
        check("err_sticky", 32'(err_a[0]), 32'd1);

        // Simultaneous push and pop at fill 1
        send(0, 32'h6000_0001);
        data_a[0] = 32'h6000_0002;
        req_a[0]  = 1'b1;
        repeat (2) @(negedge clk);
        check("pp_head_before", dout_a[0], exp0_q.pop_front());
        ready_a[0] = 1'b1;
        @(negedge clk);
        ready_a[0] = 1'b0;
        check("pp_fill", 32'(fill_a[0]), 32'd1);
        check("pp_head_after", dout_a[0], 32'h6000_0002);
        check("pp_ack", 32'(ack_a[0]), 32'd1);
        exp0_q.push_back(32'h6000_0002);
        req_a[0] = 1'b0;
        wait_ack(0, 1'b0, 20, lat);
        pop_one(0);
        check("pp_cnt", 32'(cnt0), 32'd8);

        // DEPTH=3 pointer wrap, table driven
        for (int i = 0; i < 10; i++) begin
            send(1, vecs[i].data);
            for (int p = 0; p < vecs[i].pops; p++) pop_one(1);
            check($sformatf("wrap%0d_fill", i), 32'(fill_a[1]), 32'(vecs[i].exp_fill));
            check($sformatf("wrap%0d_head", i), dout_a[1], vecs[i].exp_head);
            check($sformatf("wrap%0d_cnt", i), 32'(cnt1), 32'(vecs[i].exp_cnt));
        end
        repeat (3) pop_one(1);
        check("wrap_drain_fill", 32'(fill_a[1]), 32'd0);

        // Counter wrap: 17 transfers total on a 4-bit counter
        ready_a[1] = 1'b1;
        for (int i = 0; i < 7; i++) send(1, 32'h200 + 32'(i));
        exp1_q.delete();
        repeat (3) @(negedge clk);
        ready_a[1] = 1'b0;
        check("cnt_wrap", 32'(cnt1), 32'd1);
        check("cnt_wrap_fill", 32'(fill_a[1]), 32'd0);

        // Reset while in ACK with the FIFO full
        send(0, 32'hE000_0001);
        data_a[0] = 32'hE000_0002;
        req_a[0]  = 1'b1;
        wait_ack(0, 1'b1, 20, lat);
        check("mid_fill", 32'(fill_a[0]), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_ack", 32'(ack_a[0]), 32'd0);
        check("mrst_valid", 32'(valid_a[0]), 32'd0);
        check("mrst_data", dout_a[0], 32'd0);
        check("mrst_fill", 32'(fill_a[0]), 32'd0);
        check("mrst_cnt", 32'(cnt0), 32'd0);
        check("mrst_err", 32'(err_a[0]), 32'd0);
        req_a[0] = 1'b0;
        exp0_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(0, 32'hF000_0001);
        check("post_rst_fill", 32'(fill_a[0]), 32'd1);
        check("post_rst_cnt", 32'(cnt0), 32'd1);
        pop_one(0);
        check("post_rst_empty", 32'(valid_a[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
